// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory to Wishbone B4 pipelined single-beat master bridge.
// Optional bus timeout is enabled by defining URV_DM_TIMEOUT_EN.
module urv_dm_wb_bridge #(
  parameter int g_timeout    = 255,
  parameter int g_addr_width = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_load_i,
  input  logic        dm_store_i,
  output logic        dm_ready_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_bus_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_stall_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Word-aligned, zero-extended address window of g_addr_width bits
  localparam logic [63:0] ADDR_MASK_FULL = (64'd1 << g_addr_width) - 64'd1;
  localparam logic [31:0] ADDR_MASK      = ADDR_MASK_FULL[31:0] & 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic        we_q, err_q, cyc_q, stb_q;
  logic [31:0] adr_q, dat_q, rdat_q;
  logic [3:0]  sel_q;
  logic        take, bus_end, tmo_hit;

  assign dm_ready_o = (state_q == IDLE) || (state_q == DONE);
  assign take       = dm_ready_o && (dm_load_i || dm_store_i);
  assign bus_end    = ((state_q == WAIT) || ((state_q == ISSUE) && !wb_stall_i)) &&
                      (wb_ack_i || wb_err_i);

`ifdef URV_DM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(g_timeout - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt_q <= 16'd0;
    end else if (take) begin
      tmo_cnt_q <= 16'd0;
    end else if ((state_q == ISSUE) || (state_q == WAIT)) begin
      tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end
  end

  // A response in the final counted cycle still wins over the timeout
  assign tmo_hit = ((state_q == ISSUE) || (state_q == WAIT)) && !bus_end &&
                   (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = take ? ISSUE : IDLE;
      ISSUE: begin
        if (bus_end || tmo_hit) state_d = DONE;
        else if (!wb_stall_i)   state_d = WAIT;
      end
      WAIT: begin
        if (bus_end || tmo_hit) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Load wins when both request pulses coincide
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      adr_q   <= 32'd0;
      dat_q   <= 32'd0;
      sel_q   <= 4'd0;
      rdat_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cyc_q   <= (state_d == ISSUE) || (state_d == WAIT);
      stb_q   <= (state_d == ISSUE);
      if (take) begin
        adr_q <= dm_addr_i & ADDR_MASK;
        dat_q <= dm_data_s_i;
        we_q  <= dm_store_i && !dm_load_i;
        sel_q <= dm_load_i ? 4'hF : dm_data_select_i;
      end
      if (bus_end) begin
        err_q  <= wb_err_i;
        rdat_q <= wb_err_i ? 32'd0 : wb_dat_i;
      end else if (tmo_hit) begin
        err_q  <= 1'b1;
        rdat_q <= 32'd0;
      end
    end
  end

  assign wb_cyc_o        = cyc_q;
  assign wb_stb_o        = stb_q;
  assign wb_we_o         = we_q;
  assign wb_adr_o        = adr_q;
  assign wb_sel_o        = sel_q;
  assign wb_dat_o        = dat_q;
  assign dm_data_l_o     = rdat_q;
  assign dm_load_done_o  = (state_q == DONE) && !we_q;
  assign dm_store_done_o = (state_q == DONE) && we_q;
  assign dm_bus_err_o    = (state_q == DONE) && err_q;

endmodule
